// File: rtl/alu_pkg.sv
// Shared ALU/decode definitions: ALU op codes, operand selects, RV32I opcodes
// and the control half of the decoded micro-op.
package alu_pkg;

    localparam int ALU_SEL_W = 4;
    localparam int SEL_W     = 2;
    localparam int REG_W     = 5;
    localparam int OPC_W     = 7;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'd8;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'd9;

    localparam logic [SEL_W-1:0] OP1_RS1  = 2'b00;
    localparam logic [SEL_W-1:0] OP1_PC   = 2'b01;
    localparam logic [SEL_W-1:0] OP1_ZERO = 2'b10;
    localparam logic [SEL_W-1:0] OP2_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] OP2_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] OP2_FOUR = 2'b10;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [ALU_SEL_W-1:0] alu_sel;
        logic [SEL_W-1:0]     op1_sel;
        logic [SEL_W-1:0]     op2_sel;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [REG_W-1:0]     rd;
        logic                 reg_wen;
        logic                 branch;
        logic [2:0]           funct3;
        logic                 illegal;
    } ctrl_t;

    // Base ALU op for OP/OP-IMM; funct7[5] variants (SUB/SRA) are applied by the caller.
    function automatic logic [ALU_SEL_W-1:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I decoder: instruction word + pc -> micro-op fields.
module rv32_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o
);

    logic [OPC_W-1:0] opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             legal;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];

    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_sh = XLEN'(inst_i[24:20]);
    assign pc_o   = pc_i;

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.alu_sel = ALU_ADD;
        ctrl_o.rs1     = inst_i[19:15];
        ctrl_o.rs2     = inst_i[24:20];
        ctrl_o.rd      = inst_i[11:7];
        ctrl_o.funct3  = f3;
        imm_o          = '0;
        legal          = 1'b0;

        case (opc)
            OPC_OP: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.alu_sel = alu_from_f3(f3);
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));
                if (f7[5] && f3 == 3'b000) ctrl_o.alu_sel = ALU_SUB;
                if (f7[5] && f3 == 3'b101) ctrl_o.alu_sel = ALU_SRA;
            end
            OPC_OPIMM: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op2_sel = OP2_IMM;
                ctrl_o.alu_sel = alu_from_f3(f3);
                imm_o          = imm_i;
                legal          = 1'b1;
                // Shift immediates carry only shamt; funct7 must not leak into the operand.
                if (f3 == 3'b001) begin
                    imm_o = imm_sh;
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    imm_o = imm_sh;
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    if (f7[5]) ctrl_o.alu_sel = ALU_SRA;
                end
            end
            OPC_LUI: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op1_sel = OP1_ZERO;
                ctrl_o.op2_sel = OP2_IMM;
                imm_o          = imm_u;
                legal          = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op1_sel = OP1_PC;
                ctrl_o.op2_sel = OP2_IMM;
                imm_o          = imm_u;
                legal          = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op2_sel = OP2_IMM;
                imm_o          = imm_i;
                legal          = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                ctrl_o.op2_sel = OP2_IMM;
                imm_o          = imm_s;
                legal          = (f3[2] == 1'b0) && (f3 != 3'b011);
            end
            OPC_JAL: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op1_sel = OP1_PC;
                ctrl_o.op2_sel = OP2_FOUR;
                imm_o          = imm_j;
                legal          = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.op1_sel = OP1_PC;
                ctrl_o.op2_sel = OP2_FOUR;
                imm_o          = imm_i;
                legal          = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                ctrl_o.branch = 1'b1;
                imm_o         = imm_b;
                legal         = (f3[2:1] != 2'b01);
                case (f3[2:1])
                    2'b10:   ctrl_o.alu_sel = ALU_SLT;
                    2'b11:   ctrl_o.alu_sel = ALU_SLTU;
                    default: ctrl_o.alu_sel = ALU_SUB;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl_o.illegal = 1'b1;
            ctrl_o.alu_sel = ALU_ADD;
            ctrl_o.op1_sel = OP1_RS1;
            ctrl_o.op2_sel = OP2_RS2;
            ctrl_o.reg_wen = 1'b0;
            ctrl_o.branch  = 1'b0;
        end
        if (ctrl_o.rd == '0) ctrl_o.reg_wen = 1'b0;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: decoder feeding a main register plus one skid entry,
// giving full throughput behind a registered i_ready.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [31:0]      i_inst,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic [3:0]       o_alu_sel,
    output logic [1:0]       o_op1_sel,
    output logic [1:0]       o_op2_sel,
    output logic [XLEN-1:0]  o_imm,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic             o_reg_wen,
    output logic             o_branch,
    output logic [2:0]       o_funct3,
    output logic             o_illegal
);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } uop_t;

    localparam uop_t RST_UOP = '{ctrl: '0, imm: '0, pc: RESET_PC};

    state_t state_q, state_d;
    logic   i_ready_q;
    uop_t   main_q, skid_q, dec;
    logic   accept, pop;
    logic   load_main, load_skid, main_from_skid;

    rv32_decoder #(.XLEN(XLEN)) u_dec (
        .inst_i (i_inst),
        .pc_i   (i_pc),
        .ctrl_o (dec.ctrl),
        .imm_o  (dec.imm),
        .pc_o   (dec.pc)
    );

    assign accept = i_valid & i_ready_q;
    assign pop    = o_valid & o_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        // Flush drops both entries and any beat accepted this cycle.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = BUSY;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= EMPTY;
            i_ready_q <= 1'b1;
            main_q    <= RST_UOP;
            skid_q    <= RST_UOP;
        end else begin
            state_q   <= state_d;
            i_ready_q <= (state_d != FULL);
            if (load_main) main_q <= main_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign i_ready   = i_ready_q;
    assign o_valid   = (state_q != EMPTY);
    assign o_pc      = main_q.pc;
    assign o_imm     = main_q.imm;
    assign o_alu_sel = main_q.ctrl.alu_sel;
    assign o_op1_sel = main_q.ctrl.op1_sel;
    assign o_op2_sel = main_q.ctrl.op2_sel;
    assign o_rs1     = main_q.ctrl.rs1;
    assign o_rs2     = main_q.ctrl.rs2;
    assign o_rd      = main_q.ctrl.rd;
    assign o_reg_wen = main_q.ctrl.reg_wen;
    assign o_branch  = main_q.ctrl.branch;
    assign o_funct3  = main_q.ctrl.funct3;
    assign o_illegal = main_q.ctrl.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, skid/backpressure, flush, reset.
module tb_alu_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0080;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SRAI  = 32'h40335293;
    localparam logic [31:0] I_SLTIU = 32'hFFF13093;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_SUB   = 32'h40628233;
    localparam logic [31:0] I_LUI   = 32'h123453B7;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_XOR   = 32'h003140B3;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    logic        clock = 1'b0;
    logic        reset, flush, i_valid, i_ready, o_valid, o_ready;
    logic [31:0] i_inst, i_pc, o_pc, o_imm;
    logic [3:0]  o_alu_sel;
    logic [1:0]  o_op1_sel, o_op2_sel;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic        o_reg_wen, o_branch, o_illegal;
    logic [2:0]  o_funct3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_inst(i_inst), .i_pc(i_pc),
        .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc),
        .o_alu_sel(o_alu_sel), .o_op1_sel(o_op1_sel), .o_op2_sel(o_op2_sel),
        .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_reg_wen(o_reg_wen), .o_branch(o_branch), .o_funct3(o_funct3),
        .o_illegal(o_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        i_valid = v;
        i_inst  = inst;
        i_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; o_ready = 1'b0;
        drive(1'b1, I_SUB, 32'h0000_0F00);
        @(negedge clock);
        tick(); tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(i_ready), 32'd1);
        chk("rst_pc", o_pc, RPC);
        chk("rst_alu", 32'(o_alu_sel), 32'd0);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_wen", 32'(o_reg_wen), 32'd0);

        // Back-to-back decode vectors at full throughput
        reset = 1'b0; o_ready = 1'b1;
        drive(1'b1, I_ADD, 32'h0000_1000); tick();
        chk("add_valid", 32'(o_valid), 32'd1);
        chk("add_pc", o_pc, 32'h0000_1000);
        chk("add_alu", 32'(o_alu_sel), 32'd0);
        chk("add_op1", 32'(o_op1_sel), 32'd0);
        chk("add_op2", 32'(o_op2_sel), 32'd0);
        chk("add_rs1", 32'(o_rs1), 32'd1);
        chk("add_rs2", 32'(o_rs2), 32'd2);
        chk("add_rd", 32'(o_rd), 32'd3);
        chk("add_wen", 32'(o_reg_wen), 32'd1);

        drive(1'b1, I_SRAI, 32'h0000_1004); tick();
        chk("srai_pc", o_pc, 32'h0000_1004);
        chk("srai_alu", 32'(o_alu_sel), 32'd9);
        chk("srai_op2", 32'(o_op2_sel), 32'd1);
        chk("srai_imm", o_imm, 32'h0000_0003);
        chk("srai_rd", 32'(o_rd), 32'd5);

        drive(1'b1, I_SLTIU, 32'h0000_1008); tick();
        chk("sltiu_alu", 32'(o_alu_sel), 32'd8);
        chk("sltiu_imm", o_imm, 32'hFFFF_FFFF);
        chk("sltiu_op2", 32'(o_op2_sel), 32'd1);

        drive(1'b1, I_BLTU, 32'h0000_100C); tick();
        chk("bltu_alu", 32'(o_alu_sel), 32'd8);
        chk("bltu_br", 32'(o_branch), 32'd1);
        chk("bltu_wen", 32'(o_reg_wen), 32'd0);
        chk("bltu_f3", 32'(o_funct3), 32'd6);
        chk("bltu_imm", o_imm, 32'd8);
        chk("bltu_op2", 32'(o_op2_sel), 32'd0);

        drive(1'b1, I_SUB, 32'h0000_1010); tick();
        chk("sub_alu", 32'(o_alu_sel), 32'd1);
        chk("sub_rs2", 32'(o_rs2), 32'd6);

        drive(1'b1, I_LUI, 32'h0000_1014); tick();
        chk("lui_op1", 32'(o_op1_sel), 32'd2);
        chk("lui_op2", 32'(o_op2_sel), 32'd1);
        chk("lui_imm", o_imm, 32'h1234_5000);
        chk("lui_rd", 32'(o_rd), 32'd7);

        drive(1'b1, I_JAL, 32'h0000_2000); tick();
        chk("jal_op1", 32'(o_op1_sel), 32'd1);
        chk("jal_op2", 32'(o_op2_sel), 32'd2);
        chk("jal_wen", 32'(o_reg_wen), 32'd1);
        chk("jal_pc", o_pc, 32'h0000_2000);

        drive(1'b1, I_NOP, 32'h0000_2004); tick();
        chk("x0_wen", 32'(o_reg_wen), 32'd0);
        chk("x0_ill", 32'(o_illegal), 32'd0);

        drive(1'b1, I_BAD, 32'h0000_2008); tick();
        chk("bad_ill", 32'(o_illegal), 32'd1);
        chk("bad_alu", 32'(o_alu_sel), 32'd0);
        chk("bad_wen", 32'(o_reg_wen), 32'd0);
        chk("bad_br", 32'(o_branch), 32'd0);

        drive(1'b0, I_NOP, 32'h0); tick();
        chk("drain_valid", 32'(o_valid), 32'd0);

        // Backpressure: I0/I1 fill main+skid, I2 waits, then all drain in order
        o_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h0000_0200); tick();
        chk("bp_v0", 32'(o_valid), 32'd1);
        chk("bp_pc0", o_pc, 32'h0000_0200);
        chk("bp_rdy0", 32'(i_ready), 32'd1);
        drive(1'b1, I_SUB, 32'h0000_0204); tick();
        chk("bp_rdy_full", 32'(i_ready), 32'd0);
        chk("bp_hold0", o_pc, 32'h0000_0200);
        drive(1'b1, I_XOR, 32'h0000_0208); tick();
        chk("bp_rdy_full2", 32'(i_ready), 32'd0);
        chk("bp_hold0b", o_pc, 32'h0000_0200);
        chk("bp_hold_alu", 32'(o_alu_sel), 32'd0);
        o_ready = 1'b1; tick();
        chk("bp_pc1", o_pc, 32'h0000_0204);
        chk("bp_alu1", 32'(o_alu_sel), 32'd1);
        chk("bp_rdy1", 32'(i_ready), 32'd1);
        tick();
        chk("bp_pc2", o_pc, 32'h0000_0208);
        chk("bp_alu2", 32'(o_alu_sel), 32'd4);
        chk("bp_v2", 32'(o_valid), 32'd1);
        drive(1'b0, I_NOP, 32'h0); tick();
        chk("bp_empty", 32'(o_valid), 32'd0);

        // Flush while FULL with a beat presented
        o_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h0000_0300); tick();
        drive(1'b1, I_SUB, 32'h0000_0304); tick();
        chk("fl_full", 32'(i_ready), 32'd0);
        flush = 1'b1; drive(1'b1, I_XOR, 32'h0000_0308); tick();
        flush = 1'b0;
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ready", 32'(i_ready), 32'd1);
        drive(1'b0, I_NOP, 32'h0); o_ready = 1'b1; tick();
        chk("fl_stale1", 32'(o_valid), 32'd0);
        tick();
        chk("fl_stale2", 32'(o_valid), 32'd0);

        // Flush in BUSY discards the beat accepted the same cycle
        o_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h0000_0400); tick();
        flush = 1'b1; drive(1'b1, I_SUB, 32'h0000_0404); tick();
        flush = 1'b0; drive(1'b0, I_NOP, 32'h0);
        chk("flb_valid", 32'(o_valid), 32'd0);
        tick();
        chk("flb_stale", 32'(o_valid), 32'd0);

        // Reset while BUSY, inputs presented during reset are ignored
        drive(1'b1, I_SUB, 32'h0000_0500); tick();
        chk("rb_valid", 32'(o_valid), 32'd1);
        chk("rb_alu", 32'(o_alu_sel), 32'd1);
        reset = 1'b1; drive(1'b1, I_XOR, 32'h0000_0504); tick();
        chk("rb_rst_valid", 32'(o_valid), 32'd0);
        chk("rb_rst_pc", o_pc, RPC);
        chk("rb_rst_alu", 32'(o_alu_sel), 32'd0);
        chk("rb_rst_ready", 32'(i_ready), 32'd1);
        chk("rb_rst_rs1", 32'(o_rs1), 32'd0);
        reset = 1'b0; drive(1'b0, I_NOP, 32'h0); tick();
        chk("rb_after", 32'(o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
